// File: rtl/regfile_sequencer.sv
// Command sequencer for the 8 x DATA_W register file (R1-R4, S1-S4).
// Expands one register-transfer command into read-select, wait and write-enable cycles.
//
// state | meaning
// IDLE  | ready for a command (cmd_ready=1)
// RD    | read selects applied, waiting READ_LAT cycles for OutA/OutB
// WR1   | first write enable asserted (dst)
// WR2   | second write enable asserted (src, SWAP only)
// DONE  | one-cycle done pulse, all writes committed
module regfile_sequencer #(
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [2:0]        cmd_dst,
   input  logic [2:0]        cmd_src,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              done,
   output logic              err,
   output logic [3:0]        RegSel,
   output logic [3:0]        ScrSel,
   output logic [2:0]        FunSel,
   output logic [2:0]        OutASel,
   output logic [2:0]        OutBSel,
   output logic [DATA_W-1:0] rf_i,
   input  logic [DATA_W-1:0] OutA,
   input  logic [DATA_W-1:0] OutB
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WR1, S_WR2, S_DONE} state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_CLR  = 3'b001;
   localparam logic [2:0] OP_LDI  = 3'b010;
   localparam logic [2:0] OP_INC  = 3'b011;
   localparam logic [2:0] OP_DEC  = 3'b100;
   localparam logic [2:0] OP_MOV  = 3'b101;
   localparam logic [2:0] OP_SWAP = 3'b110;
   localparam logic [2:0] OP_RSV  = 3'b111;

   localparam logic [2:0] FN_CLR  = 3'b000;
   localparam logic [2:0] FN_LOAD = 3'b001;
   localparam logic [2:0] FN_INC  = 3'b010;
   localparam logic [2:0] FN_DEC  = 3'b011;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [2:0]          dst_q, dst_d;
   logic [2:0]          src_q, src_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [7:0]          en_q, en_d;
   logic [2:0]          fun_q, fun_d;
   logic [2:0]          asel_q, asel_d;
   logic [2:0]          bsel_q, bsel_d;
   logic [DATA_W-1:0]   rfi_q, rfi_d;
   logic                accept;

   // Combined enable vector {RegSel,ScrSel}: index 0 (R1) is the MSB, index 7 (S4) the LSB.
   function automatic logic [7:0] dec_en(input logic [2:0] idx);
      return 8'h80 >> idx;
   endfunction

   function automatic logic [2:0] fun_code(input logic [2:0] op);
      case (op)
         OP_LDI:  return FN_LOAD;
         OP_INC:  return FN_INC;
         OP_DEC:  return FN_DEC;
         default: return FN_CLR;
      endcase
   endfunction

   assign accept = cmd_valid && ready_q && (state_q == S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         dst_q   <= '0;
         src_q   <= '0;
         cnt_q   <= '0;
         b_q     <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         en_q    <= '0;
         fun_q   <= FN_CLR;
         asel_q  <= '0;
         bsel_q  <= '0;
         rfi_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         b_q     <= b_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
         en_q    <= en_d;
         fun_q   <= fun_d;
         asel_q  <= asel_d;
         bsel_q  <= bsel_d;
         rfi_q   <= rfi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_NOP, OP_RSV:  state_d = S_DONE;
                  OP_MOV, OP_SWAP: state_d = S_RD;
                  default:         state_d = S_WR1;
               endcase
            end
         end
         S_RD:    if (cnt_q == 2'd0) state_d = S_WR1;
         S_WR1:   state_d = (op_q == OP_SWAP) ? S_WR2 : S_DONE;
         S_WR2:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      op_d    = op_q;
      dst_d   = dst_q;
      src_d   = src_q;
      cnt_d   = cnt_q;
      b_d     = b_q;
      ready_d = (state_d == S_IDLE);
      done_d  = 1'b0;
      err_d   = 1'b0;
      en_d    = '0;
      fun_d   = fun_q;
      asel_d  = asel_q;
      bsel_d  = bsel_q;
      rfi_d   = rfi_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = cmd_op;
               dst_d = cmd_dst;
               src_d = cmd_src;
               cnt_d = 2'(READ_LAT - 1);
               case (cmd_op)
                  OP_NOP: done_d = 1'b1;
                  OP_RSV: begin
                     done_d = 1'b1;
                     err_d  = 1'b1;
                  end
                  OP_MOV: asel_d = cmd_src;
                  OP_SWAP: begin
                     asel_d = cmd_src;
                     bsel_d = cmd_dst;
                  end
                  default: begin
                     en_d  = dec_en(cmd_dst);
                     fun_d = fun_code(cmd_op);
                     rfi_d = (cmd_op == OP_LDI) ? cmd_imm : '0;
                  end
               endcase
            end
         end
         S_RD: begin
            // Read ports are valid on the last RD cycle; OutB is parked until WR2.
            if (cnt_q == 2'd0) begin
               rfi_d = OutA;
               b_d   = OutB;
               en_d  = dec_en(dst_q);
               fun_d = FN_LOAD;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_WR1: begin
            if (op_q == OP_SWAP) begin
               en_d  = dec_en(src_q);
               fun_d = FN_LOAD;
               rfi_d = b_q;
            end else begin
               done_d = 1'b1;
            end
         end
         S_WR2:   done_d = 1'b1;
         default: ;
      endcase
   end

   assign cmd_ready = ready_q;
   assign done      = done_q;
   assign err       = err_q;
   assign RegSel    = en_q[7:4];
   assign ScrSel    = en_q[3:0];
   assign FunSel    = fun_q;
   assign OutASel   = asel_q;
   assign OutBSel   = bsel_q;
   assign rf_i      = rfi_q;

endmodule
